// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over one single-port 128x40 SRAM, 2-entry output buffer; SRAM_FIFO_BYPASS_EN lets words skip an empty SRAM.
// Latency: enq to deq_valid is 3 cycles through the SRAM, 1 cycle with SRAM_FIFO_BYPASS_EN when the SRAM is empty.
// Backpressure: enq_ready drops when the SRAM is full or a favoured read takes the port; reads stop while the obuf is committed.
module sram_fifo_ctrl #(
    parameter int DATA_W = 40,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int OBUF_D = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data,
    output logic [7:0]        count,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] a_hold;
    logic [CNT_W-1:0]  sram_cnt;
    logic              rd_inflight;
    logic              prio;
    logic [DATA_W-1:0] obuf [2];
    logic              obuf_head;
    logic [1:0]        obuf_cnt;

    logic run;
    logic not_full;
    logic rd_req;
    logic wr_req;
    logic byp_ok;
    logic byp_fire;
    logic rd_gnt;
    logic wr_gnt;
    logic contended;
    logic obuf_push;
    logic obuf_pop;
    logic obuf_tail;
    logic [DATA_W-1:0] push_dat;

    assign run      = !reset;
    assign not_full = sram_cnt != CNT_W'(DEPTH);
    assign rd_req   = (sram_cnt != '0) && ((32'(obuf_cnt) + 32'(rd_inflight)) < OBUF_D);
    assign wr_req   = enq_valid && not_full;

`ifdef SRAM_FIFO_BYPASS_EN
    assign byp_ok = (sram_cnt == '0) && !rd_inflight && (32'(obuf_cnt) < OBUF_D) && !rd_req;
`else
    assign byp_ok = 1'b0;
`endif

    // Read wins a contended cycle when prio is 0; enq_ready mirrors the write grant without looking at enq_valid.
    assign enq_ready = run && not_full && !(rd_req && !prio);
    assign rd_gnt    = run && rd_req && (!wr_req || !prio);
    assign wr_gnt    = run && wr_req && !byp_ok && (!rd_req || prio);
    assign byp_fire  = run && byp_ok && enq_valid && enq_ready;
    assign contended = run && rd_req && wr_req;

    assign sram_csb = !(wr_gnt || rd_gnt);
    assign sram_web = !wr_gnt;
    assign sram_oeb = !rd_gnt;
    assign sram_i   = enq_data;

    always_comb begin
        sram_a = a_hold;
        if (wr_gnt) begin
            sram_a = wr_ptr;
        end else if (rd_gnt) begin
            sram_a = rd_ptr;
        end
    end

    // A read issued last cycle has its word on sram_o now; bypass and capture are mutually exclusive.
    assign obuf_push = rd_inflight || byp_fire;
    assign push_dat  = rd_inflight ? sram_o : enq_data;
    assign obuf_tail = obuf_head ^ obuf_cnt[0];

    assign deq_valid = run && (obuf_cnt != 2'd0);
    assign deq_data  = obuf[obuf_head];
    assign obuf_pop  = deq_valid && deq_ready;

    assign count = 8'(sram_cnt) + 8'(rd_inflight) + 8'(obuf_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            a_hold      <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
            prio        <= 1'b0;
            obuf_head   <= 1'b0;
            obuf_cnt    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                obuf[i] <= '0;
            end
        end else begin
            if (wr_gnt) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_gnt) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_gnt || rd_gnt) begin
                a_hold <= sram_a;
            end
            if (wr_gnt) begin
                sram_cnt <= sram_cnt + 1'b1;
            end else if (rd_gnt) begin
                sram_cnt <= sram_cnt - 1'b1;
            end
            rd_inflight <= rd_gnt;
            if (contended) begin
                prio <= !prio;
            end
            if (obuf_push) begin
                obuf[obuf_tail] <= push_dat;
            end
            if (obuf_pop) begin
                obuf_head <= !obuf_head;
            end
            obuf_cnt <= obuf_cnt + 2'(obuf_push) - 2'(obuf_pop);
        end
    end

endmodule
